// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD line responder: receives 48-bit host commands, checks framing/CRC7,
// reports good ones and answers with an R1 frame NCR sd_clk rising edges after the end bit.
module sd_cmd_responder #(
  parameter int unsigned NCR = 2
) (
  input  logic        PCLK_i,
  input  logic        PRESETn_i,
  input  logic        sd_clk_i,
  input  logic        sd_cmd_i,
  output logic        sd_cmd_o,
  output logic        sd_cmd_oe_o,
  input  logic [31:0] card_status_i,
  output logic        cmd_valid_o,
  output logic [5:0]  cmd_index_o,
  output logic [31:0] cmd_arg_o,
  output logic        frame_err_o
);

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_CHECK, S_WAIT, S_SEND} state_e;

  localparam logic [6:0] NCR_INIT = 7'(NCR);

  state_e      state_q;
  logic        sd_clk_q;
  logic [45:0] rx_q;
  logic [38:0] tx_q;
  logic [6:0]  crc_q;
  logic [6:0]  cnt_q;
  logic [31:0] status_q;
  logic        cmd_q;
  logic        oe_q;
  logic        valid_q;
  logic        err_q;
  logic [5:0]  index_q;
  logic [31:0] arg_q;

  logic        rise;
  logic        fall;
  logic [6:0]  crc_rx_d;
  logic [6:0]  crc_tx_d;
  logic        frame_ok_d;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign rise = sd_clk_i & ~sd_clk_q;
  assign fall = ~sd_clk_i & sd_clk_q;

  assign crc_rx_d = crc7_step(crc_q, sd_cmd_i);
  assign crc_tx_d = crc7_step(crc_q, tx_q[38]);

  // Judged on the bit-0 sample itself: rx_q holds bits 46..1, the end bit is on the pin.
  assign frame_ok_d = rx_q[45] & sd_cmd_i & (rx_q[6:0] == crc_q);

  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      state_q  <= S_IDLE;
      sd_clk_q <= 1'b0;
      rx_q     <= '0;
      tx_q     <= '0;
      crc_q    <= '0;
      cnt_q    <= '0;
      status_q <= '0;
      cmd_q    <= 1'b1;
      oe_q     <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      index_q  <= '0;
      arg_q    <= '0;
    end else begin
      sd_clk_q <= sd_clk_i;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          oe_q  <= 1'b0;
          cmd_q <= 1'b1;
          if (rise && !sd_cmd_i) begin
            crc_q   <= '0;
            cnt_q   <= 7'd47;
            state_q <= S_RECV;
          end
        end
        S_RECV: begin
          if (rise) begin
            if (cnt_q == 7'd1) begin
              valid_q <= frame_ok_d;
              err_q   <= ~frame_ok_d;
              if (frame_ok_d) begin
                index_q <= rx_q[44:39];
                arg_q   <= rx_q[38:7];
              end
              cnt_q   <= '0;
              state_q <= S_CHECK;
            end else begin
              rx_q <= {rx_q[44:0], sd_cmd_i};
              if (cnt_q >= 7'd9) crc_q <= crc_rx_d;
              cnt_q <= cnt_q - 7'd1;
            end
          end
        end
        S_CHECK: begin
          if (valid_q) status_q <= card_status_i;
          // CMD0 has no response; any error also returns straight to idle.
          if (valid_q && index_q != 6'd0) begin
            cnt_q   <= NCR_INIT;
            state_q <= S_WAIT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt_q == 7'd0) begin
            if (fall) begin
              oe_q    <= 1'b1;
              cmd_q   <= 1'b0;
              crc_q   <= '0;
              tx_q    <= {1'b0, index_q, status_q};
              cnt_q   <= 7'd47;
              state_q <= S_SEND;
            end
          end else if (rise) begin
            cnt_q <= cnt_q - 7'd1;
          end
        end
        S_SEND: begin
          // cnt_q is the index of the bit currently on the line.
          if (fall) begin
            if (cnt_q == 7'd0) begin
              oe_q    <= 1'b0;
              cmd_q   <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              cnt_q <= cnt_q - 7'd1;
              if (cnt_q >= 7'd9) begin
                cmd_q <= tx_q[38];
                tx_q  <= {tx_q[37:0], 1'b0};
                crc_q <= crc_tx_d;
              end else if (cnt_q >= 7'd2) begin
                cmd_q <= crc_q[6];
                crc_q <= {crc_q[5:0], 1'b0};
              end else begin
                cmd_q <= 1'b1;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sd_cmd_o    = cmd_q;
  assign sd_cmd_oe_o = oe_q;
  assign cmd_valid_o = valid_q;
  assign frame_err_o = err_q;
  assign cmd_index_o = index_q;
  assign cmd_arg_o   = arg_q;

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Scoreboard bench for sd_cmd_responder: two instances (NCR=2 and NCR=64) share the host
// side; a monitor checks command events and serial responses of the selected instance.
`timescale 1ns/1ps
module tb_sd_cmd_responder;

  logic        PCLK;
  logic        PRESETn;
  logic        sd_clk;
  logic        sd_cmd;
  logic [31:0] status;
  logic        sel;

  logic        a_cmd, a_oe, a_valid, a_err;
  logic [5:0]  a_idx;
  logic [31:0] a_arg;
  logic        b_cmd, b_oe, b_valid, b_err;
  logic [5:0]  b_idx;
  logic [31:0] b_arg;

  logic        m_cmd, m_oe, m_valid, m_err;
  logic [5:0]  m_idx;
  logic [31:0] m_arg;

  typedef struct { bit is_err; logic [5:0] idx; logic [31:0] arg; } ev_t;
  typedef struct { logic [5:0] idx; logic [31:0] status; int ncr; } rsp_t;

  ev_t  ev_q[$];
  rsp_t rsp_q[$];

  int checks = 0;
  int failures = 0;
  int resp_done = 0;
  int resp_starts = 0;
  int resp_aborted = 0;
  int n_valid = 0;
  int n_err = 0;
  int mon_nbits = 0;

  sd_cmd_responder #(.NCR(2)) u_dut (
    .PCLK_i(PCLK), .PRESETn_i(PRESETn), .sd_clk_i(sd_clk), .sd_cmd_i(sd_cmd),
    .sd_cmd_o(a_cmd), .sd_cmd_oe_o(a_oe), .card_status_i(status),
    .cmd_valid_o(a_valid), .cmd_index_o(a_idx), .cmd_arg_o(a_arg), .frame_err_o(a_err)
  );

  sd_cmd_responder #(.NCR(64)) u_dut64 (
    .PCLK_i(PCLK), .PRESETn_i(PRESETn), .sd_clk_i(sd_clk), .sd_cmd_i(sd_cmd),
    .sd_cmd_o(b_cmd), .sd_cmd_oe_o(b_oe), .card_status_i(status),
    .cmd_valid_o(b_valid), .cmd_index_o(b_idx), .cmd_arg_o(b_arg), .frame_err_o(b_err)
  );

  assign m_cmd   = sel ? b_cmd   : a_cmd;
  assign m_oe    = sel ? b_oe    : a_oe;
  assign m_valid = sel ? b_valid : a_valid;
  assign m_err   = sel ? b_err   : a_err;
  assign m_idx   = sel ? b_idx   : a_idx;
  assign m_arg   = sel ? b_arg   : a_arg;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // sd_clk = PCLK/8, toggled away from the active PCLK edge
  initial begin
    sd_clk = 1'b0;
    forever begin
      repeat (4) @(negedge PCLK);
      sd_clk = ~sd_clk;
    end
  end

  function automatic logic [6:0] crc7_model(input logic [39:0] d);
    logic [6:0] c;
    c = 7'd0;
    for (int i = 39; i >= 0; i--)
      c = {c[5:0], 1'b0} ^ ((d[i] ^ c[6]) ? 7'h09 : 7'h00);
    return c;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      @(negedge sd_clk);
      sd_cmd = f[i];
    end
    @(negedge sd_clk);
    sd_cmd = 1'b1;
  endtask

  task automatic wait_resp_done(input int target, input string name);
    int n;
    n = 0;
    while (resp_done < target && n < 6000) begin
      @(posedge PCLK);
      n++;
    end
    check(name, resp_done, target);
  endtask

  task automatic push_ev(input bit is_err, input logic [5:0] idx, input logic [31:0] arg);
    ev_t e;
    e.is_err = is_err; e.idx = idx; e.arg = arg;
    ev_q.push_back(e);
  endtask

  task automatic push_rsp(input logic [5:0] idx, input logic [31:0] st, input int ncr);
    rsp_t r;
    r.idx = idx; r.status = st; r.ncr = ncr;
    rsp_q.push_back(r);
  endtask

  // Monitor: samples 2ns after each PCLK rise, host samples CMD on sd_clk rising edges.
  initial begin : monitor
    logic        sd_prev, oe_prev, collecting, rise_s;
    int          rises_since, oe_rises;
    logic [47:0] got;
    rsp_t        cur;
    ev_t         e;
    sd_prev = 1'b0; oe_prev = 1'b0; collecting = 1'b0;
    rises_since = 0; oe_rises = 0; got = '0;
    cur.idx = '0; cur.status = '0; cur.ncr = 0;
    forever begin
      @(posedge PCLK);
      #2;
      rise_s  = sd_clk & ~sd_prev;
      sd_prev = sd_clk;
      if (!PRESETn) begin
        if (collecting) resp_aborted++;
        collecting = 1'b0;
        oe_prev    = 1'b0;
      end else begin
        if (m_valid || m_err) begin
          if (m_valid) n_valid++;
          if (m_err) n_err++;
          if (ev_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_event: got valid=%0b err=%0b expected none", m_valid, m_err);
          end else begin
            e = ev_q.pop_front();
            check("event_err_flag", {63'd0, m_err}, {63'd0, e.is_err});
            check("event_valid_flag", {63'd0, m_valid}, {63'd0, ~e.is_err});
            if (!e.is_err) begin
              check("cmd_index", {58'd0, m_idx}, {58'd0, e.idx});
              check("cmd_arg", {32'd0, m_arg}, {32'd0, e.arg});
            end
          end
        end
        if (m_valid) rises_since = 0;
        else if (rise_s) rises_since++;
        if (m_oe && !oe_prev) begin
          resp_starts++;
          if (rsp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_response: got oe=1 expected none");
          end else begin
            cur = rsp_q.pop_front();
            check("ncr_gap", rises_since, cur.ncr);
            collecting = 1'b1;
            mon_nbits  = 0;
            oe_rises   = 0;
            got        = '0;
          end
        end
        if (collecting && rise_s) begin
          if (m_oe) oe_rises++;
          if (mon_nbits < 48) got[47 - mon_nbits] = m_cmd;
          mon_nbits++;
        end
        if (collecting && !m_oe && oe_prev) begin
          check("resp_len", oe_rises, 48);
          check("resp_frame", {16'd0, got},
                {16'd0, 2'b00, cur.idx, cur.status,
                 crc7_model({2'b00, cur.idx, cur.status}), 1'b1});
          collecting = 1'b0;
          resp_done++;
        end
        oe_prev = m_oe;
      end
    end
  end

  initial begin : stim
    int n;
    int starts_before;
    PRESETn = 1'b0;
    sd_cmd  = 1'b1;
    status  = 32'd0;
    sel     = 1'b0;
    repeat (3) @(negedge PCLK);
    check("rst_cmd_o", {63'd0, a_cmd}, 64'd1);
    check("rst_oe", {63'd0, a_oe}, 64'd0);
    check("rst_valid", {63'd0, a_valid}, 64'd0);
    check("rst_err", {63'd0, a_err}, 64'd0);
    check("rst_index", {58'd0, a_idx}, 64'd0);
    check("rst_arg", {32'd0, a_arg}, 64'd0);
    PRESETn = 1'b1;
    repeat (16) @(negedge PCLK);

    // CMD17, arg 0
    status = 32'h0000_0900;
    push_ev(1'b0, 6'd17, 32'd0);
    push_rsp(6'd17, 32'h0000_0900, 2);
    send_cmd(48'h51_0000_0000_55);
    wait_resp_done(1, "cmd17_resp_done");
    check("cmd17_valid_count", n_valid, 1);
    check("cmd17_events_left", ev_q.size(), 0);

    // CMD17 with a corrupted CRC
    push_ev(1'b1, 6'd0, 32'd0);
    send_cmd(48'h51_0000_0000_57);
    repeat (100 * 8) @(negedge PCLK);
    check("badcrc_err_count", n_err, 1);
    check("badcrc_valid_count", n_valid, 1);
    check("badcrc_index_held", {58'd0, a_idx}, 64'd17);
    check("badcrc_no_resp", resp_starts, 1);

    // CMD17 with the transmission bit cleared
    push_ev(1'b1, 6'd0, 32'd0);
    send_cmd(48'h11_0000_0000_55);
    repeat (100 * 8) @(negedge PCLK);
    check("badtx_err_count", n_err, 2);
    check("badtx_no_resp", resp_starts, 1);

    // CMD0: reported, never answered
    push_ev(1'b0, 6'd0, 32'd0);
    send_cmd(48'h40_0000_0000_95);
    repeat (100 * 8) @(negedge PCLK);
    check("cmd0_valid_count", n_valid, 2);
    check("cmd0_index", {58'd0, a_idx}, 64'd0);
    check("cmd0_no_resp", resp_starts, 1);
    check("cmd0_oe_low", {63'd0, a_oe}, 64'd0);

    // CMD8 on the NCR=64 instance, once it has surely drained
    repeat (150 * 8) @(negedge PCLK);
    sel    = 1'b1;
    status = 32'h0000_0120;
    push_ev(1'b0, 6'd8, 32'h0000_01AA);
    push_rsp(6'd8, 32'h0000_0120, 64);
    send_cmd(48'h48_0000_01AA_87);
    wait_resp_done(2, "cmd8_ncr64_resp_done");
    check("cmd8_ncr64_events_left", ev_q.size(), 0);
    repeat (20 * 8) @(negedge PCLK);
    sel = 1'b0;
    repeat (8) @(negedge PCLK);

    // Reset in the middle of a response
    status = 32'h0000_0900;
    starts_before = resp_starts;
    push_ev(1'b0, 6'd8, 32'h0000_01AA);
    push_rsp(6'd8, 32'h0000_0900, 2);
    send_cmd(48'h48_0000_01AA_87);
    n = 0;
    while (!(resp_starts > starts_before && mon_nbits >= 20) && n < 6000) begin
      @(negedge PCLK);
      n++;
    end
    check("rstmid_reached_bit20", {63'd0, (resp_starts > starts_before && mon_nbits >= 20)}, 64'd1);
    @(negedge PCLK);
    PRESETn = 1'b0;
    #1;
    check("rstmid_oe_drop", {63'd0, a_oe}, 64'd0);
    check("rstmid_cmd_high", {63'd0, a_cmd}, 64'd1);
    repeat (3) @(negedge PCLK);
    check("rstmid_no_valid", {63'd0, a_valid}, 64'd0);
    check("rstmid_no_err", {63'd0, a_err}, 64'd0);
    PRESETn = 1'b1;
    check("rstmid_aborted", resp_aborted, 1);
    repeat (16) @(negedge PCLK);

    push_ev(1'b0, 6'd8, 32'h0000_01AA);
    push_rsp(6'd8, 32'h0000_0900, 2);
    send_cmd(48'h48_0000_01AA_87);
    wait_resp_done(3, "post_reset_cmd8_resp_done");
    repeat (20 * 8) @(negedge PCLK);

    check("final_events_left", ev_q.size(), 0);
    check("final_resps_left", rsp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
